// File: rtl/serial_sum_collector.sv
// Receive side of a bit-serial two's-complement adder: gathers LSB-first sum bits
// into a parallel word and derives carry-out / signed overflow from the MSB slice.
module serial_sum_collector #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             s_in,
    input  logic             a_in,
    input  logic             b_in,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry_out;
    logic             r_overflow;
    logic             r_busy;
    logic             r_done;

    // The carry into the MSB slice is recovered from that slice's own sum bit.
    logic             w_cin_msb;
    logic             w_carry_next;
    logic             w_overflow_next;
    logic [WIDTH-1:0] w_word_next;
    logic             w_last_bit;

    assign w_cin_msb       = s_in ^ a_in ^ b_in;
    assign w_carry_next    = (a_in & b_in) | (w_cin_msb & (a_in ^ b_in));
    assign w_overflow_next = w_cin_msb ^ w_carry_next;
    assign w_word_next     = {s_in, r_shift[WIDTH-1:1]};
    assign w_last_bit      = (r_count == LAST_BIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_shift     <= '0;
            r_sum       <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state <= COLLECT;
                        r_count <= '0;
                        r_shift <= '0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                COLLECT: begin
                    // start takes priority over any bit presented in the same cycle
                    if (start) begin
                        r_count <= '0;
                        r_shift <= '0;
                    end else if (bit_valid) begin
                        if (w_last_bit) begin
                            r_sum       <= w_word_next;
                            r_carry_out <= w_carry_next;
                            r_overflow  <= w_overflow_next;
                            r_state     <= DONE;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                        end else begin
                            r_shift <= w_word_next;
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign sum       = r_sum;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_serial_sum_collector.sv
// Directed bench for serial_sum_collector: drives adder-generated serial words and
// checks the assembled sum, flags and handshake outputs.
module tb_serial_sum_collector;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       bit_valid = 1'b0;
    logic       s_in = 1'b0;
    logic       a_in = 1'b0;
    logic       b_in = 1'b0;
    logic [7:0] sum;
    logic       carry_out;
    logic       overflow;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    serial_sum_collector #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bit_valid (bit_valid),
        .s_in      (s_in),
        .a_in      (a_in),
        .b_in      (b_in),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        bit_valid = 1'b0;
        tick();
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
    endtask

    // Feed bits [0..nbits-1] of a+b as a ripple adder would; optional idle gaps.
    task automatic feed_bits(input logic [7:0] a, input logic [7:0] b, input int nbits,
                             input int gap_max);
        logic c = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (gap_max > 0) begin
                int g = $urandom_range(1, gap_max);
                bit_valid = 1'b0;
                for (int k = 0; k < g; k++) begin
                    tick();
                    check("gap_no_done", 32'(done), 32'd0);
                end
            end
            a_in = a[i];
            b_in = b[i];
            s_in = a[i] ^ b[i] ^ c;
            c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
            bit_valid = 1'b1;
            tick();
            if (i < 7) begin
                check("no_early_done", 32'(done), 32'd0);
                check("busy_mid", 32'(busy), 32'd1);
            end
        end
        bit_valid = 1'b0;
    endtask

    task automatic send_word(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input int gap_max, input logic [7:0] exp_sum,
                             input logic exp_c, input logic exp_v);
        feed_bits(a, b, 8, gap_max);
        $display("word %s: a=0x%02h b=0x%02h sum=0x%02h c=%0b v=%0b done=%0b",
                 tag, a, b, sum, carry_out, overflow, done);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
        check({tag, "_carry"}, 32'(carry_out), 32'(exp_c));
        check({tag, "_ovf"}, 32'(overflow), 32'(exp_v));
    endtask

    task automatic to_idle();
        bit_valid = 1'b0;
        tick();
        check("idle_done_low", 32'(done), 32'd0);
        check("idle_busy_low", 32'(busy), 32'd0);
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_carry", 32'(carry_out), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);

        // Basic words, no gaps
        do_start();
        send_word("w05_03", 8'h05, 8'h03, 0, 8'h08, 1'b0, 1'b0);
        to_idle();
        do_start();
        send_word("w7f_01", 8'h7F, 8'h01, 0, 8'h80, 1'b0, 1'b1);
        to_idle();
        do_start();
        send_word("wff_01", 8'hFF, 8'h01, 0, 8'h00, 1'b1, 1'b0);
        to_idle();

        // Same result with random idle gaps between bits
        do_start();
        send_word("w80_80g", 8'h80, 8'h80, 5, 8'h00, 1'b1, 1'b1);
        to_idle();

        // Abort after 4 bits; the coincident bit on the restart is discarded
        do_start();
        feed_bits(8'h12, 8'h34, 4, 0);
        check("abort_sum_held", 32'(sum), 32'h00);
        start = 1'b1;
        bit_valid = 1'b1;
        s_in = 1'b1;
        a_in = 1'b1;
        b_in = 1'b0;
        tick();
        start = 1'b0;
        bit_valid = 1'b0;
        check("abort_busy", 32'(busy), 32'd1);
        check("abort_no_done", 32'(done), 32'd0);
        check("abort_sum_held2", 32'(sum), 32'h00);
        check("abort_carry_held", 32'(carry_out), 32'd1);
        send_word("w01_01", 8'h01, 8'h01, 0, 8'h02, 1'b0, 1'b0);
        to_idle();

        // Reset in the middle of a word
        do_start();
        feed_bits(8'hAA, 8'h11, 5, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_carry", 32'(carry_out), 32'd0);
        check("midrst_ovf", 32'(overflow), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        bit_valid = 1'b1;
        s_in = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("nostart_done", 32'(done), 32'd0);
            check("nostart_busy", 32'(busy), 32'd0);
        end
        bit_valid = 1'b0;
        do_start();
        send_word("w05_03b", 8'h05, 8'h03, 0, 8'h08, 1'b0, 1'b0);
        to_idle();

        // Back-to-back words, start asserted in the DONE cycle
        do_start();
        send_word("w0f_01", 8'h0F, 8'h01, 0, 8'h10, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_done_low", 32'(done), 32'd0);
        send_word("w40_40", 8'h40, 8'h40, 0, 8'h80, 1'b0, 1'b1);
        to_idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
